// File: rtl/simple_comp_result_fifo.sv
// First-word-fall-through result FIFO behind simple_comp, with occupancy count and sticky overflow.
// Optional change filter (push only when d_in differs from the last pushed word): SIMPLE_COMP_CHANGE_FILTER_EN.
module simple_comp_result_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   LP_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_cand;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == LP_FULL);
    assign w_empty = (r_count == '0);

`ifdef SIMPLE_COMP_CHANGE_FILTER_EN
    logic [WIDTH-1:0] r_last_word;
    logic             r_have_last;

    // Repeats of the last accepted word are not push candidates at all.
    assign w_cand = in_valid & (~r_have_last | (d_in != r_last_word));

    always_ff @(posedge clock) begin
        if (rst) begin
            r_last_word <= '0;
            r_have_last <= 1'b0;
        end else if (w_push) begin
            r_last_word <= d_in;
            r_have_last <= 1'b1;
        end
    end
`else
    assign w_cand = in_valid;
`endif

    // No push-through when full, even if the head is popped this edge.
    assign w_push = w_cand & ~w_full;
    assign w_pop  = ~w_empty & out_ready;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= d_in;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_cand & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_simple_comp_result_fifo.sv
// Self-checking bench for simple_comp_result_fifo: directed scenarios plus random traffic
// against a queue-based reference model (honours SIMPLE_COMP_CHANGE_FILTER_EN).
module tb_simple_comp_result_fifo;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  d_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] q[$];
    bit               m_ovf  = 1'b0;
    bit               m_have = 1'b0;
    logic [WIDTH-1:0] m_last = '0;
    bit               m_popped_v = 1'b0;
    logic [WIDTH-1:0] m_popped = '0;

    simple_comp_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .rst      (rst),
        .d_in     (d_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("count",     32'(count),     32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
        chk("out_data",  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic drive(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit ordy);
        rst = r; in_valid = v; d_in = d; out_ready = ordy;
    endtask

    // Advance one edge, updating the model from the inputs seen at that edge.
    task automatic cycle();
        bit cand, push;
        m_popped_v = 1'b0;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_have = 1'b0; m_last = '0;
        end else begin
            cand = in_valid;
`ifdef SIMPLE_COMP_CHANGE_FILTER_EN
            if (m_have && d_in == m_last) cand = 1'b0;
`endif
            push = cand && (q.size() < DEPTH);
            if (cand && q.size() == DEPTH) m_ovf = 1'b1;
            if (out_ready && q.size() > 0) begin
                m_popped = q.pop_front();
                m_popped_v = 1'b1;
            end
            if (push) begin
                q.push_back(d_in);
                m_last = d_in; m_have = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic drain();
        drive(0, 0, '0, 1);
        for (int i = 0; i < DEPTH + 2; i++) cycle();
    endtask

    logic [WIDTH-1:0] exp2 [3];
    logic [WIDTH-1:0] nxt;
    int               expc;

    initial begin
        exp2[0] = 16'h0FFF; exp2[1] = 16'h0000; exp2[2] = 16'h0666;

        // Reset for two edges
        drive(1, 0, '0, 0);
        cycle(); cycle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Three pushes, then drain in order
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, exp2[i], 0);
            cycle();
        end
        chk("t2_count3", 32'(count), 32'd3);
        drive(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_head", 32'(out_data), 32'(exp2[i]));
            cycle();
        end
        chk("t2_empty_valid", 32'(out_valid), 32'd0);
        chk("t2_empty_count", 32'(count), 32'd0);

        // Nine pushes into eight entries
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, WIDTH'(i), 0);
            cycle();
            if (i == 8) chk("t3_in_ready_full", 32'(in_ready), 32'd0);
        end
        chk("t3_count8", 32'(count), 32'd8);
        chk("t3_overflow", 32'(overflow), 32'd1);
        drive(0, 0, '0, 1);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain", 32'(out_data), 32'(i));
            cycle();
        end
        chk("t3_drained", 32'(out_valid), 32'd0);

        // Steady push+pop at count=4, pointers wrap
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, WIDTH'(16'h0100 + i), 0);
            cycle();
        end
        nxt = 16'h0100;
        for (int i = 4; i < 24; i++) begin
            drive(0, 1, WIDTH'(16'h0100 + i), 1);
            cycle();
            chk("t4_count_held", 32'(count), 32'd4);
            chk("t4_seq", 32'(m_popped_v ? m_popped : '0), 32'(nxt));
            nxt = nxt + 16'h1;
        end
        drain();

        // Reset mid-stream wins over a push
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, WIDTH'(16'h0200 + i), 0);
            cycle();
        end
        chk("t5_count5", 32'(count), 32'd5);
        drive(1, 1, 16'h0BAD, 0);
        cycle();
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_overflow", 32'(overflow), 32'd0);
        drive(0, 1, 16'h1234, 0);
        cycle();
        chk("t5_next_push", 32'(out_data), 32'h1234);
        chk("t5_next_valid", 32'(out_valid), 32'd1);

        // Held value then a change
        drive(1, 0, '0, 0);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 16'h0666, 0);
            cycle();
        end
        drive(0, 1, 16'h0FFF, 0);
        cycle();
`ifdef SIMPLE_COMP_CHANGE_FILTER_EN
        expc = 2;
        chk("t6_overflow", 32'(overflow), 32'd0);
`else
        expc = 8;
        chk("t6_overflow", 32'(overflow), 32'd1);
`endif
        chk("t6_count", 32'(count), 32'(expc));
        drive(0, 0, '0, 1);
        chk("t6_head", 32'(out_data), 32'h0666);
        cycle();
        chk("t6_second", 32'(out_data), (expc == 2) ? 32'h0FFF : 32'h0666);
        drain();

        // Random traffic with a small data alphabet and occasional resets
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  WIDTH'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
